cache_axi_bridge: RTL and testbench

CACHE_AXI_BRIDGE -- requirements
Module: cache_axi_bridge

---
 rtl/cache_axi_pkg.sv | 33 +++
 rtl/cache_axi_bridge_if.sv | 95 +++++++++
 rtl/bridge_arbiter.sv | 62 ++++++
 rtl/cache_axi_bridge.sv | 185 ++++++++++++++++++
 tb/tb_cache_axi_bridge.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_axi_pkg.sv
// Shared types and constants for the cache-to-AXI bridge: FSM states, AXI IDs,
// the fixed single-beat AXI sideband values, and the write-strobe helper.
package cache_axi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RADDR,
    S_RDATA,
    S_WADDR,
    S_WRESP
  } bridge_state_e;

  localparam logic [3:0] ID_INST = 4'd0;
  localparam logic [3:0] ID_DATA = 4'd1;

  localparam logic [7:0] AXI_LEN_SINGLE  = 8'd0;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_LOCK_NORMAL = 2'b00;
  localparam logic [3:0] AXI_CACHE_NONE  = 4'b0000;
  localparam logic [2:0] AXI_PROT_NONE   = 3'b000;

  // Byte lanes touched by a cache store; word and larger sizes enable all four lanes.
  function automatic logic [3:0] size_to_wstrb(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] strb;
    case (size)
      2'b00:   strb = 4'b0001 << offset;
      2'b01:   strb = 4'b0011 << offset;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/cache_axi_bridge_if.sv
// Bundle of the inst/data cache ports and the AXI master channels.
// The master modport is the bridge's view; slave is the caches-plus-memory view.
interface cache_axi_bridge_if;

  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic [31:0] inst_rdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_addr_ok;
  logic        data_data_ok;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic        bvalid;
  logic        bready;

  modport master (
    input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    output inst_rdata, inst_addr_ok, inst_data_ok,
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_rdata, data_addr_ok, data_data_ok,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bvalid,
    output bready
  );

  modport slave (
    output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    input  inst_rdata, inst_addr_ok, inst_data_ok,
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_rdata, data_addr_ok, data_data_ok,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bvalid,
    input  bready
  );

endinterface

// File: rtl/bridge_arbiter.sv
// Picks one of the inst/data cache requests while the bridge is idle; grant is one-hot
// with bit 0 = inst and bit 1 = data. Define ARB_RR_EN for round-robin conflict resolution.
module bridge_arbiter #(
  parameter logic ARB_INIT = 1'b1
) (
`ifdef ARB_RR_EN
  input  logic       clk,
  input  logic       rst,
`endif
  input  logic       inst_req,
  input  logic       data_req,
  input  logic       idle,
  output logic [1:0] grant
);

`ifdef ARB_RR_EN
  logic prefer_data_q, prefer_data_d;

  // On a conflict the pointer decides; after any grant it swings to the other port.
  always_comb begin
    grant = 2'b00;
    if (idle) begin
      if (inst_req && data_req) begin
        grant = prefer_data_q ? 2'b10 : 2'b01;
      end else if (data_req) begin
        grant = 2'b10;
      end else if (inst_req) begin
        grant = 2'b01;
      end
    end
    prefer_data_d = prefer_data_q;
    if (grant[1]) begin
      prefer_data_d = 1'b0;
    end else if (grant[0]) begin
      prefer_data_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prefer_data_q <= ARB_INIT;
    end else begin
      prefer_data_q <= prefer_data_d;
    end
  end
`else
  logic unused_arb_init;
  assign unused_arb_init = ARB_INIT;

  always_comb begin
    grant = 2'b00;
    if (idle) begin
      if (data_req) begin
        grant = 2'b10;
      end else if (inst_req) begin
        grant = 2'b01;
      end
    end
  end
`endif

endmodule

// File: rtl/cache_axi_bridge.sv
// Bridges the inst and data cache ports onto one AXI master, one transaction at a time.
// Optional macro ARB_RR_EN switches same-cycle conflicts from data-first to round-robin.
module cache_axi_bridge
  import cache_axi_pkg::*;
#(
  parameter logic ARB_INIT = 1'b1
) (
  input logic                clk,
  input logic                rst,
  cache_axi_bridge_if.master bus
);

  bridge_state_e state_q, state_d;
  logic          owner_q, owner_d;
  logic          wr_q, wr_d;
  logic [1:0]    size_q, size_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          aw_done_q, aw_done_d;
  logic          w_done_q, w_done_d;

  logic [1:0]    grant;
  logic          idle;
  logic          xfer_ok;
  logic          arvalid, rready, awvalid, wvalid, bready;
  logic          aw_now, w_now;
  logic [3:0]    axi_id;
  logic          unused_ids;

  assign idle = (state_q == S_IDLE);

  bridge_arbiter #(
    .ARB_INIT(ARB_INIT)
  ) u_arbiter (
`ifdef ARB_RR_EN
    .clk     (clk),
    .rst     (rst),
`endif
    .inst_req(bus.inst_req),
    .data_req(bus.data_req),
    .idle    (idle),
    .grant   (grant)
  );

  // Transaction FSM; owner_q = 1 marks the data port as the requester in flight.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    wr_d      = wr_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    xfer_ok   = 1'b0;
    aw_now    = 1'b0;
    w_now     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant[1]) begin
          owner_d = 1'b1;
          wr_d    = bus.data_wr;
          size_d  = bus.data_size;
          addr_d  = bus.data_addr;
          wdata_d = bus.data_wdata;
          state_d = bus.data_wr ? S_WADDR : S_RADDR;
        end else if (grant[0]) begin
          owner_d = 1'b0;
          wr_d    = bus.inst_wr;
          size_d  = bus.inst_size;
          addr_d  = bus.inst_addr;
          wdata_d = bus.inst_wdata;
          state_d = bus.inst_wr ? S_WADDR : S_RADDR;
        end
      end
      S_RADDR: begin
        arvalid = 1'b1;
        if (bus.arready) begin
          state_d = S_RDATA;
        end
      end
      S_RDATA: begin
        rready = 1'b1;
        if (bus.rvalid && !wr_q) begin
          xfer_ok = 1'b1;
          state_d = S_IDLE;
        end
      end
      // Address and data channels finish independently; leave once both are done.
      S_WADDR: begin
        awvalid = !aw_done_q;
        wvalid  = !w_done_q;
        aw_now  = aw_done_q || bus.awready;
        w_now   = w_done_q || bus.wready;
        if (aw_now && w_now) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_WRESP;
        end else begin
          aw_done_d = aw_now;
          w_done_d  = w_now;
        end
      end
      S_WRESP: begin
        bready = 1'b1;
        if (bus.bvalid && wr_q) begin
          xfer_ok = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      wr_q      <= 1'b0;
      size_q    <= 2'b00;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      wr_q      <= wr_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign axi_id = owner_q ? ID_DATA : ID_INST;

  assign bus.inst_addr_ok = grant[0];
  assign bus.data_addr_ok = grant[1];
  assign bus.inst_data_ok = xfer_ok && !owner_q;
  assign bus.data_data_ok = xfer_ok && owner_q;
  assign bus.inst_rdata   = bus.rdata;
  assign bus.data_rdata   = bus.rdata;

  assign bus.arid    = axi_id;
  assign bus.araddr  = addr_q;
  assign bus.arlen   = AXI_LEN_SINGLE;
  assign bus.arsize  = {1'b0, size_q};
  assign bus.arburst = AXI_BURST_INCR;
  assign bus.arlock  = AXI_LOCK_NORMAL;
  assign bus.arcache = AXI_CACHE_NONE;
  assign bus.arprot  = AXI_PROT_NONE;
  assign bus.arvalid = arvalid;
  assign bus.rready  = rready;

  assign bus.awid    = axi_id;
  assign bus.awaddr  = addr_q;
  assign bus.awlen   = AXI_LEN_SINGLE;
  assign bus.awsize  = {1'b0, size_q};
  assign bus.awburst = AXI_BURST_INCR;
  assign bus.awlock  = AXI_LOCK_NORMAL;
  assign bus.awcache = AXI_CACHE_NONE;
  assign bus.awprot  = AXI_PROT_NONE;
  assign bus.awvalid = awvalid;

  assign bus.wid     = axi_id;
  assign bus.wdata   = wdata_q;
  assign bus.wstrb   = size_to_wstrb(size_q, addr_q[1:0]);
  assign bus.wlast   = 1'b1;
  assign bus.wvalid  = wvalid;
  assign bus.bready  = bready;

  // With one transaction in flight the response IDs carry no information.
  assign unused_ids = ^{bus.rid, bus.bid};

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed and randomized checks of cache_axi_bridge against a word-memory model
// and the arbitration/strobe rules; the bench plays both caches and the AXI slave.
module tb_cache_axi_bridge;

  localparam logic ARB_INIT_TB = 1'b1;

  logic clk = 1'b0;
  logic rst;
  int   nChecks = 0;
  int   nFails  = 0;
`ifdef ARB_RR_EN
  logic modelPreferData;
`endif
  logic [31:0] mem [logic [31:0]];

  cache_axi_bridge_if bus ();

  cache_axi_bridge #(
    .ARB_INIT(ARB_INIT_TB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFails++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic clearInputs();
    bus.inst_req = 1'b0; bus.inst_wr = 1'b0; bus.inst_size = 2'b00;
    bus.inst_addr = 32'd0; bus.inst_wdata = 32'd0;
    bus.data_req = 1'b0; bus.data_wr = 1'b0; bus.data_size = 2'b00;
    bus.data_addr = 32'd0; bus.data_wdata = 32'd0;
    bus.arready = 1'b0; bus.rid = 4'd0; bus.rdata = 32'd0; bus.rvalid = 1'b0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bid = 4'd0; bus.bvalid = 1'b0;
  endtask

  // Both cache ports get the same command; the inst port's address differs in bit 8.
  task automatic applyStimulus(input logic iReq, input logic dReq, input logic wr,
                               input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    bus.inst_req = iReq; bus.inst_wr = wr; bus.inst_size = size;
    bus.inst_addr = addr ^ 32'h0000_0100; bus.inst_wdata = wdata;
    bus.data_req = dReq; bus.data_wr = wr; bus.data_size = size;
    bus.data_addr = addr; bus.data_wdata = wdata;
  endtask

  function automatic int modelWinner(input logic iReq, input logic dReq);
    if (iReq && dReq) begin
`ifdef ARB_RR_EN
      return modelPreferData ? 1 : 0;
`else
      return 1;
`endif
    end
    return dReq ? 1 : 0;
  endfunction

  function automatic logic [3:0] modelWstrb(input logic [1:0] size, input logic [31:0] addr);
    int lane;
    int v;
    lane = int'(addr % 4);
    if (size == 2'd0) v = 1 << lane;
    else if (size == 2'd1) v = (3 << lane) % 16;
    else v = 15;
    return v[3:0];
  endfunction

  function automatic logic [31:0] modelReadWord(input logic [31:0] addr);
    logic [31:0] key;
    key = addr & 32'hFFFF_FFFC;
    if (!mem.exists(key)) mem[key] = $urandom;
    return mem[key];
  endfunction

  function automatic void modelWrite(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
    logic [31:0] key;
    logic [31:0] word;
    key = addr & 32'hFFFF_FFFC;
    word = mem.exists(key) ? mem[key] : 32'd0;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) word[8*b +: 8] = wdata[8*b +: 8];
    end
    mem[key] = word;
  endfunction

  task automatic issueRequest(input logic iReq, input logic dReq, input logic wr, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output int winner, output logic [31:0] grantedAddr, output logic sawDataOk);
    @(negedge clk);
    applyStimulus(iReq, dReq, wr, size, addr, wdata);
    #1;
    winner = modelWinner(iReq, dReq);
    grantedAddr = (winner == 1) ? addr : (addr ^ 32'h0000_0100);
    sawDataOk = bus.data_addr_ok;
    checkOutput("inst_addr_ok", bus.inst_addr_ok, (winner == 0));
    checkOutput("data_addr_ok", bus.data_addr_ok, (winner == 1));
`ifdef ARB_RR_EN
    modelPreferData = (winner == 0);
`endif
  endtask

  task automatic finishRead(input int winner, input logic [31:0] addr, input logic [1:0] size,
                            input int arDelay, input int rDelay);
    logic [31:0] word;
    word = modelReadWord(addr);
    for (int c = 0; c <= arDelay; c++) begin
      @(negedge clk);
      bus.inst_req = 1'b1; bus.data_req = 1'b1;
      bus.arready = (c == arDelay);
      #1;
      checkOutput("arvalid", bus.arvalid, 1'b1);
      checkOutput("busy_addr_ok", {bus.inst_addr_ok, bus.data_addr_ok}, 2'b00);
      if (c == 0) begin
        checkOutput("araddr", bus.araddr, addr);
        checkOutput("arsize", bus.arsize, {1'b0, size});
        checkOutput("arid", bus.arid, (winner == 1) ? 4'd1 : 4'd0);
        checkOutput("awvalid_in_read", bus.awvalid, 1'b0);
      end
    end
    for (int c = 0; c <= rDelay; c++) begin
      @(negedge clk);
      bus.arready = 1'b0;
      bus.rvalid = (c == rDelay);
      bus.rdata = (c == rDelay) ? word : $urandom;
      #1;
      checkOutput("rready", bus.rready, 1'b1);
      checkOutput("arvalid_after_hs", bus.arvalid, 1'b0);
      checkOutput("inst_data_ok", bus.inst_data_ok, (c == rDelay) && (winner == 0));
      checkOutput("data_data_ok", bus.data_data_ok, (c == rDelay) && (winner == 1));
      if (c == rDelay) begin
        checkOutput("owner_rdata", (winner == 1) ? bus.data_rdata : bus.inst_rdata, word);
      end
    end
    @(negedge clk);
    bus.rvalid = 1'b0; bus.inst_req = 1'b0; bus.data_req = 1'b0;
    #1;
    checkOutput("idle_rready", bus.rready, 1'b0);
    checkOutput("idle_data_ok", {bus.inst_data_ok, bus.data_data_ok}, 2'b00);
  endtask

  task automatic finishWrite(input int winner, input logic [31:0] addr, input logic [1:0] size,
                             input logic [31:0] wdata, input int awDelay, input int wDelay, input int bDelay);
    int last;
    logic [3:0] strb;
    last = (awDelay > wDelay) ? awDelay : wDelay;
    strb = modelWstrb(size, addr);
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      bus.inst_req = 1'b1; bus.data_req = 1'b1;
      bus.awready = (c == awDelay);
      bus.wready = (c == wDelay);
      #1;
      checkOutput("awvalid", bus.awvalid, (c <= awDelay));
      checkOutput("wvalid", bus.wvalid, (c <= wDelay));
      checkOutput("busy_ok", {bus.inst_addr_ok, bus.data_addr_ok, bus.inst_data_ok, bus.data_data_ok}, 4'd0);
      if (c == 0) begin
        checkOutput("awaddr", bus.awaddr, addr);
        checkOutput("awsize", bus.awsize, {1'b0, size});
        checkOutput("awid", bus.awid, (winner == 1) ? 4'd1 : 4'd0);
        checkOutput("wdata", bus.wdata, wdata);
        checkOutput("wstrb", bus.wstrb, strb);
        checkOutput("wlast", bus.wlast, 1'b1);
        checkOutput("arvalid_in_write", bus.arvalid, 1'b0);
      end
      if (c == wDelay) modelWrite(addr, wdata, strb);
    end
    for (int c = 0; c <= bDelay; c++) begin
      @(negedge clk);
      bus.awready = 1'b0; bus.wready = 1'b0;
      bus.bvalid = (c == bDelay);
      #1;
      checkOutput("bready", bus.bready, 1'b1);
      checkOutput("resp_aw_w_valid", {bus.awvalid, bus.wvalid}, 2'b00);
      checkOutput("inst_data_ok", bus.inst_data_ok, (c == bDelay) && (winner == 0));
      checkOutput("data_data_ok", bus.data_data_ok, (c == bDelay) && (winner == 1));
    end
    @(negedge clk);
    bus.bvalid = 1'b0; bus.inst_req = 1'b0; bus.data_req = 1'b0;
    #1;
    checkOutput("idle_bready", bus.bready, 1'b0);
    checkOutput("idle_data_ok", {bus.inst_data_ok, bus.data_data_ok}, 2'b00);
  endtask

  initial begin
    int winner;
    logic [31:0] gAddr;
    logic sawData;
    logic [3:0] order;
    logic iReq, dReq, wr;
    logic [1:0] size;
    logic [31:0] addr, wdata;

    clearInputs();
    rst = 1'b1;
`ifdef ARB_RR_EN
    modelPreferData = ARB_INIT_TB;
`endif
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_valids", {bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready}, 5'd0);
    checkOutput("reset_oks", {bus.inst_addr_ok, bus.data_addr_ok, bus.inst_data_ok, bus.data_data_ok}, 4'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] four back-to-back conflicting grants");
    order = 4'd0;
    for (int k = 0; k < 4; k++) begin
      issueRequest(1'b1, 1'b1, 1'b0, 2'b10, 32'h3000_0000 + 32'(k * 16), 32'd0, winner, gAddr, sawData);
      order[k] = sawData;
      finishRead(winner, gAddr, 2'b10, 0, 1);
    end
`ifdef ARB_RR_EN
    checkOutput("grant_order", order, 4'b0101);
`else
    checkOutput("grant_order", order, 4'b1111);
`endif

    $display("[TB] directed data read and writes");
    mem[32'h1000_0004] = 32'hDEAD_BEEF;
    issueRequest(1'b0, 1'b1, 1'b0, 2'b10, 32'h1000_0004, 32'd0, winner, gAddr, sawData);
    finishRead(winner, gAddr, 2'b10, 2, 0);

    issueRequest(1'b0, 1'b1, 1'b1, 2'b00, 32'h1000_0013, 32'hAB00_0000, winner, gAddr, sawData);
    finishWrite(winner, gAddr, 2'b00, 32'hAB00_0000, 1, 0, 2);

    issueRequest(1'b0, 1'b1, 1'b1, 2'b10, 32'h1000_0020, 32'h1234_5678, winner, gAddr, sawData);
    finishWrite(winner, gAddr, 2'b10, 32'h1234_5678, 3, 0, 0);

    issueRequest(1'b1, 1'b0, 1'b1, 2'b01, 32'h1000_0032, 32'hCAFE_0000, winner, gAddr, sawData);
    finishWrite(winner, gAddr, 2'b01, 32'hCAFE_0000, 0, 0, 1);

    $display("[TB] reset while waiting for read data");
    issueRequest(1'b0, 1'b1, 1'b0, 2'b10, 32'h1000_0040, 32'd0, winner, gAddr, sawData);
    @(negedge clk);
    bus.data_req = 1'b0; bus.arready = 1'b1;
    #1;
    checkOutput("rst_pre_arvalid", bus.arvalid, 1'b1);
    @(negedge clk);
    bus.arready = 1'b0;
    #1;
    checkOutput("rst_pre_rready", bus.rready, 1'b1);
    @(negedge clk);
    rst = 1'b1; bus.rvalid = 1'b1; bus.rdata = 32'h5555_AAAA;
    #1;
    checkOutput("rst_arvalid_rready", {bus.arvalid, bus.rready}, 2'b00);
    checkOutput("rst_data_ok", {bus.inst_data_ok, bus.data_data_ok}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_rready", bus.rready, 1'b0);
    checkOutput("post_rst_data_ok", {bus.inst_data_ok, bus.data_data_ok}, 2'b00);
    @(negedge clk);
    bus.rvalid = 1'b0;
    #1;
    checkOutput("post_rst_idle_ok", {bus.inst_data_ok, bus.data_data_ok}, 2'b00);
`ifdef ARB_RR_EN
    modelPreferData = ARB_INIT_TB;
`endif
    issueRequest(1'b1, 1'b0, 1'b0, 2'b10, 32'h1000_0004, 32'd0, winner, gAddr, sawData);
    finishRead(winner, gAddr, 2'b10, 1, 1);

    $display("[TB] randomized transactions");
    for (int t = 0; t < 24; t++) begin
      dReq = 1'($urandom_range(0, 1));
      iReq = dReq ? 1'($urandom_range(0, 1)) : 1'b1;
      wr = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      addr = 32'h2000_0000 + 32'($urandom_range(0, 31));
      wdata = $urandom;
      issueRequest(iReq, dReq, wr, size, addr, wdata, winner, gAddr, sawData);
      if (wr) begin
        finishWrite(winner, gAddr, size, wdata, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      end else begin
        finishRead(winner, gAddr, size, $urandom_range(0, 3), $urandom_range(0, 3));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule
